// File: rtl/tx_fifo_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: default sizing of the
// byte path and the encoding of the issue controller states.
package tx_fifo_feeder_pkg;

  // Default configuration of the transmit path
  localparam int TX_DATA_WIDTH  = 8;
  localparam int TX_FIFO_DEPTH  = 16;
  localparam int TX_ADDR_WIDTH  = $clog2(TX_FIFO_DEPTH);
  localparam int TX_ACK_TIMEOUT = 8;

  // Issue controller states; encoding 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } feeder_state_t;

  // Width of a counter able to hold the values 0..limit-1 (never below 1 bit)
  function automatic int counter_width(input int limit);
    int w;
    w = $clog2(limit);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo_feeder_if.sv
// Host write port, transmitter handshake and status bundle of the feeder.
// slave is the feeder's view; master is the view of the surrounding logic.
interface tx_fifo_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr_flags;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overflow;
  logic                  ack_err;

  modport slave (
    input  wr_en, wr_data, clr_flags, tx_busy,
    output tx_data, tx_data_valid, full, empty, fifo_count, overflow, ack_err
  );

  modport master (
    output wr_en, wr_data, clr_flags, tx_busy,
    input  tx_data, tx_data_valid, full, empty, fifo_count, overflow, ack_err
  );

endinterface

// File: rtl/tx_fifo_feeder_sync_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers. Occupancy is the pointer
// difference, so full/empty fall straight out of the count. A write into a
// full FIFO is only accepted when a pop frees a slot in the same cycle;
// otherwise it is dropped and the sticky overflow flag is raised.
module sync_fifo
  import tx_fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int FIFO_DEPTH = TX_FIFO_DEPTH,
  parameter int ADDR_WIDTH = TX_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  // Storage is deliberately left unreset; only the pointers define contents
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Pointer advance; the extra top bit distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow; a dropped write wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_fifo_feeder.sv
// Byte buffer and issue controller in front of the UART transmitter.
// Bytes are popped one at a time and presented with a one-cycle valid
// pulse while the transmitter is idle; the controller then waits for the
// transmitter to acknowledge (busy rises) and to finish the frame before
// issuing again. A missing acknowledge discards the byte and raises ack_err.
module tx_fifo_feeder
  import tx_fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = TX_DATA_WIDTH,
  parameter int FIFO_DEPTH  = TX_FIFO_DEPTH,
  parameter int ADDR_WIDTH  = TX_ADDR_WIDTH,
  parameter int ACK_TIMEOUT = TX_ACK_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  tx_fifo_feeder_if.slave bus
);

  localparam int                   CNT_WIDTH = counter_width(ACK_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);

  feeder_state_t         state;
  feeder_state_t         state_next;
  logic                  issue;
  logic                  ack_timeout;
  logic [CNT_WIDTH-1:0]  ack_cnt;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  ack_err_q;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  fifo_overflow;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (bus.wr_en),
    .wr_data      (bus.wr_data),
    .rd_en        (issue),
    .clr_overflow (bus.clr_flags),
    .head         (fifo_head),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .overflow     (fifo_overflow)
  );

  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign bus.full          = fifo_full;
  assign bus.empty         = fifo_empty;
  assign bus.fifo_count    = fifo_count;
  assign bus.overflow      = fifo_overflow;
  assign bus.ack_err       = ack_err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the issue and timeout strobes
  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    ack_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          issue      = 1'b1;
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (ack_cnt == CNT_LAST) begin
          ack_timeout = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Acknowledge timeout counter, restarted on every issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt <= '0;
    end else if (issue || ack_timeout) begin
      ack_cnt <= '0;
    end else if (state == ST_WAIT_ACK && !bus.tx_busy) begin
      ack_cnt <= ack_cnt + 1'b1;
    end
  end

  // Registered byte and one-cycle valid pulse; the byte holds until the next issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= issue;
      if (issue) begin
        tx_data_q <= fifo_head;
      end
    end
  end

  // Sticky acknowledge error; a new timeout wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_err_q <= 1'b0;
    end else if (ack_timeout) begin
      ack_err_q <= 1'b1;
    end else if (bus.clr_flags) begin
      ack_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Directed bench for tx_fifo_feeder with a small transmitter model that
// raises busy one cycle after each valid pulse and holds it for 11 cycles.
module tb_tx_fifo_feeder;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_flags;
  logic       manual_busy;
  logic       model_en;
  logic       model_busy;
  logic       model_pend;
  int         model_left;

  int         checks;
  int         failures;
  logic [7:0] got[$];
  int         base;
  int         unstable;

  tx_fifo_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  tx_fifo_feeder #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (16),
    .ADDR_WIDTH  (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.wr_en     = wr_en;
  assign bus.wr_data   = wr_data;
  assign bus.clr_flags = clr_flags;
  assign bus.tx_busy   = model_en ? model_busy : manual_busy;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: busy one cycle after valid, held for 11 cycles
  always @(negedge clk) begin
    if (rst || !model_en) begin
      model_busy = 1'b0;
      model_pend = 1'b0;
      model_left = 0;
    end else begin
      if (model_left > 0) begin
        model_left = model_left - 1;
        if (model_left == 0) model_busy = 1'b0;
      end
      if (model_pend) begin
        model_busy = 1'b1;
        model_left = 11;
        model_pend = 1'b0;
      end
      if (bus.tx_data_valid === 1'b1) model_pend = 1'b1;
    end
  end

  // Record every byte issued with a valid pulse
  always @(negedge clk) begin
    if (bus.tx_data_valid === 1'b1) got.push_back(bus.tx_data);
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle write, called and returning on a falling edge
  task automatic applyStimulus(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    clr_flags   = 1'b0;
    manual_busy = 1'b0;
    model_en    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("rst_valid", 32'(bus.tx_data_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h00);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_ack_err", 32'(bus.ack_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte into an idle block
    $display("[TB] single byte");
    model_en = 1'b1;
    base = got.size();
    applyStimulus(8'hA5);
    checkOutput("single_stored_valid", 32'(bus.tx_data_valid), 32'd0);
    checkOutput("single_stored_count", 32'(bus.fifo_count), 32'd1);
    @(negedge clk);
    checkOutput("single_valid", 32'(bus.tx_data_valid), 32'd1);
    checkOutput("single_tx_data", 32'(bus.tx_data), 32'hA5);
    checkOutput("single_popped_empty", 32'(bus.empty), 32'd1);
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tx_data !== 8'hA5) unstable = unstable + 1;
    end
    checkOutput("single_tx_data_hold", 32'(unstable), 32'd0);
    checkOutput("single_pulse_count", 32'(got.size() - base), 32'd1);
    checkOutput("single_end_empty", 32'(bus.empty), 32'd1);

    // Burst while an external frame keeps the transmitter busy
    $display("[TB] burst with external busy");
    model_en    = 1'b0;
    manual_busy = 1'b1;
    base = got.size();
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
    checkOutput("burst_full", 32'(bus.full), 32'd1);
    checkOutput("burst_count16", 32'(bus.fifo_count), 32'd16);
    repeat (3) @(negedge clk);
    checkOutput("ext_busy_no_issue", 32'(got.size() - base), 32'd0);

    // Busy falls while a write hits the full FIFO on the issue edge
    manual_busy = 1'b0;
    model_en    = 1'b1;
    applyStimulus(8'h11);
    checkOutput("ext_busy_release_valid", 32'(bus.tx_data_valid), 32'd1);
    checkOutput("ext_busy_release_data", 32'(bus.tx_data), 32'h01);
    checkOutput("full_pop_count", 32'(bus.fifo_count), 32'd16);
    checkOutput("full_pop_overflow", 32'(bus.overflow), 32'd0);

    // Write into a full FIFO with no pop is dropped
    applyStimulus(8'h12);
    checkOutput("overflow_set", 32'(bus.overflow), 32'd1);
    checkOutput("overflow_count", 32'(bus.fifo_count), 32'd16);

    for (int k = 0; k < 600 && (got.size() - base) < 17; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    checkOutput("burst_pulse_count", 32'(got.size() - base), 32'd17);
    if (got.size() - base >= 17) begin
      for (int i = 0; i < 17; i++) checkOutput($sformatf("burst_order_%0d", i), 32'(got[base+i]), 32'(i + 1));
    end
    checkOutput("burst_drained_empty", 32'(bus.empty), 32'd1);
    checkOutput("overflow_sticky", 32'(bus.overflow), 32'd1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("overflow_cleared", 32'(bus.overflow), 32'd0);

    // Acknowledge timeout
    $display("[TB] ack timeout");
    model_en    = 1'b0;
    manual_busy = 1'b0;
    applyStimulus(8'h3C);
    applyStimulus(8'h4D);
    for (int k = 0; k < 10 && bus.tx_data_valid !== 1'b1; k++) @(negedge clk);
    checkOutput("to_first_valid", 32'(bus.tx_data_valid), 32'd1);
    checkOutput("to_first_data", 32'(bus.tx_data), 32'h3C);
    repeat (7) @(negedge clk);
    checkOutput("to_before_limit", 32'(bus.ack_err), 32'd0);
    @(negedge clk);
    checkOutput("to_at_limit", 32'(bus.ack_err), 32'd1);
    @(negedge clk);
    checkOutput("to_next_valid", 32'(bus.tx_data_valid), 32'd1);
    checkOutput("to_next_data", 32'(bus.tx_data), 32'h4D);
    repeat (7) @(negedge clk);
    checkOutput("to_sticky", 32'(bus.ack_err), 32'd1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("to_clr_collide", 32'(bus.ack_err), 32'd1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checkOutput("to_cleared", 32'(bus.ack_err), 32'd0);

    // Asynchronous reset in the middle of a frame
    $display("[TB] reset mid-frame");
    model_en = 1'b1;
    base = got.size();
    applyStimulus(8'h55);
    repeat (3) @(negedge clk);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    checkOutput("midrst_queued", 32'(bus.fifo_count), 32'd3);
    checkOutput("midrst_tx_data_before", 32'(bus.tx_data), 32'h55);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
    checkOutput("midrst_valid", 32'(bus.tx_data_valid), 32'd0);
    checkOutput("midrst_tx_data", 32'(bus.tx_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midrst_no_issue", 32'(got.size() - base), 32'd1);
    checkOutput("midrst_still_empty", 32'(bus.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_fifo_feeder.md
Name: tx_fifo_feeder

Overview:
Byte buffer and issue controller sitting directly upstream of the UART transmit FSM/serializer. Host logic writes bytes into an internal FIFO at any rate. The block pops one byte at a time and presents it with a single-cycle data-valid pulse when the transmitter is idle. It then tracks the transmitter's busy flag until the frame completes before issuing the next byte.

Parameters:
DATA_WIDTH, 8, width of each byte/word handed to the transmitter
FIFO_DEPTH, 16, number of FIFO entries; power of two, minimum 2
ADDR_WIDTH, 4, log2(FIFO_DEPTH); FIFO pointers carry one extra wrap bit
ACK_TIMEOUT, 8, cycles to wait for tx_busy to rise after a valid pulse; minimum 2

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  DATA_WIDTH  byte to enqueue
clr_flags  input  1  synchronous clear of the overflow and ack_err sticky flags
tx_busy  input  1  busy flag from the transmit FSM
tx_data  output  DATA_WIDTH  byte presented to the serializer; registered
tx_data_valid  output  1  one-cycle issue pulse to the transmit FSM; registered
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: a write was attempted while full
ack_err  output  1  sticky: tx_busy failed to rise within ACK_TIMEOUT cycles

Behaviour:
- Reset (RST=1, asynchronous) forces the following, all taking effect immediately without waiting for a clock edge, including mid-frame:
  - pointers and fifo_count = 0; empty = 1; full = 0
  - tx_data = 0; tx_data_valid = 0; overflow = 0; ack_err = 0
  - FSM = IDLE; timeout counter = 0
- FIFO:
  - full and empty are decoded combinationally from fifo_count.
  - Write accepted when wr_en=1 and either (full=0) or (full=1 and a pop occurs the same cycle).
  - Write while full with no pop is dropped; overflow is set on the next edge.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Storage is not reset; only the pointers are.
- FSM states: IDLE, WAIT_ACK, WAIT_DONE.
  - IDLE: if empty=0 and tx_busy=0, then at the edge:
    - tx_data <= head entry
    - read pointer increments (pop)
    - tx_data_valid <= 1
    - timeout counter <= 0
    - state <= WAIT_ACK
    - Otherwise hold.
  - WAIT_ACK:
    - tx_data_valid <= 0 at the first edge (pulse is exactly one cycle).
    - tx_busy=1 → WAIT_DONE.
    - Otherwise the counter increments; when the counter reaches ACK_TIMEOUT-1 with tx_busy still 0: ack_err <= 1 and state <= IDLE. The byte is discarded, not retried.
  - WAIT_DONE: tx_busy=0 → IDLE; otherwise hold.
  - tx_data holds its value from issue until the next issue.
- Issue latency:
  - Write into an empty FIFO while idle → tx_data_valid high 2 cycles after the wr_en cycle (one edge to store, one to issue).
  - Minimum gap between valid pulses: valid cycle + 1 ack cycle + frame duration + 1 IDLE cycle.
  - The transmitter's back-to-back STOP→START path is intentionally never used.
- Sticky flags:
  - clr_flags=1 clears overflow and ack_err at the edge.
  - If a set event and clr_flags=1 occur in the same cycle, set wins.
- tx_busy already high in IDLE (frame from another source): no issue until it drops.
- Unused FSM encodings return to IDLE.

Decomposition:
- Shared package/macro include holds:
  - FSM state encodings (IDLE=2'd0, WAIT_ACK=2'd1, WAIT_DONE=2'd2)
  - DATA_WIDTH and FIFO_DEPTH defaults, alongside the existing Tx configuration macros
- One natural sub-module: sync_fifo (storage, pointers, count, full/empty, overflow detect).
- The feeder FSM, timeout counter and output registers live in tx_fifo_feeder.

Test Plan:
1. Reset mid-frame: assert RST while in WAIT_DONE with 3 entries queued → tx_data_valid=0, fifo_count=0, empty=1 immediately, no issue after release.
2. Single byte: write 0xA5 to an idle block with a model TX that raises tx_busy 1 cycle after valid and holds it for 11 cycles → exactly one valid pulse 2 cycles after the write, tx_data=0xA5 stable throughout, return to IDLE, empty=1.
3. Burst: write 0x01..0x10 back-to-back (16 writes) → full=1 after the 16th write; 17th write sets overflow; bytes emerge in order 0x01..0x10 with one valid pulse per frame; clr_flags then clears overflow.
4. Full plus simultaneous pop: FIFO full, wr_en coincident with an issue cycle → write accepted, fifo_count stays 16, overflow stays 0.
5. Ack timeout: tx_busy held 0 after a valid pulse → ack_err=1 exactly ACK_TIMEOUT cycles after the pulse; the next queued byte issues from IDLE; clr_flags coincident with a new timeout leaves ack_err=1.
6. External busy: tx_busy=1 while idle with data queued → no valid pulse until tx_busy falls, then issue on the following edge.
